// File: rtl/bcd_to_binary_if.sv
// bcd_to_binary_if: start/ready/done handshake plus BCD operand and binary result
// for the bcd_to_binary converter.
interface bcd_to_binary_if #(
   parameter int N_DIGITS  = 8,
   parameter int BIN_WIDTH = 26
);
   logic                 start;
   logic [3:0]           BCD_value [N_DIGITS-1:0];
   logic [BIN_WIDTH-1:0] binary_value;
   logic                 ready;
   logic                 done;
   logic                 overflow;
   logic                 error;
   modport master (output start, BCD_value, input binary_value, ready, done, overflow, error);
   modport slave  (input start, BCD_value, output binary_value, ready, done, overflow, error);
endinterface

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential reverse double-dabble packed-BCD to binary converter.
// Define BCD_DIGIT_CHECK_EN to reject digits > 9 with error instead of converting them.
module bcd_to_binary #(
   parameter int N_DIGITS  = 8,
   parameter int BIN_WIDTH = 26
) (
   input logic             clk,
   input logic             rstN,
   bcd_to_binary_if.slave  bus
);
   function automatic int calc_shifts(int n);
      longint unsigned p = 1;
      int s = 0;
      for (int i = 0; i < n; i++) p = p * 10;
      while ((64'd1 << s) < p) s++;
      return s;
   endfunction
   localparam int SHIFTS = calc_shifts(N_DIGITS);
   localparam int BW     = N_DIGITS * 4;
   localparam int CW     = $clog2(SHIFTS);
   localparam int W      = SHIFTS > BIN_WIDTH ? SHIFTS : BIN_WIDTH;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t          state, state_nx;
   logic            start_q, trig, bad, last;
   logic [BW-1:0]   bcd, bcd_in, bcd_rs, bcd_sh;
   logic [SHIFTS-1:0] acc, acc_sh;
   logic [W-1:0]    acc_w;
   logic [CW-1:0]   cnt;
   always_comb begin
      bcd_in = '0;
      for (int i = 0; i < N_DIGITS; i++) bcd_in[4*i +: 4] = bus.BCD_value[i];
   end
`ifdef BCD_DIGIT_CHECK_EN
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) bad |= bus.BCD_value[i] > 4'd9;
   end
`else
   assign bad = 1'b0;
`endif
   // One reverse double-dabble step: shift right, then correct every digit that reached 8+.
   always_comb begin
      acc_sh = {bcd[0], acc[SHIFTS-1:1]};
      bcd_rs = bcd >> 1;
      bcd_sh = '0;
      for (int i = 0; i < N_DIGITS; i++)
         bcd_sh[4*i +: 4] = bcd_rs[4*i +: 4] >= 4'd8 ? bcd_rs[4*i +: 4] - 4'd3 : bcd_rs[4*i +: 4];
   end
   assign acc_w = W'(acc_sh);
   assign trig  = bus.start && !start_q && state == IDLE;
   assign last  = cnt == CW'(SHIFTS - 1);
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = trig ? (bad ? DONE : SHIFT) : IDLE;
         SHIFT:   state_nx = last ? DONE : SHIFT;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state            <= IDLE;
         start_q          <= 1'b1;
         bcd              <= '0;
         acc              <= '0;
         cnt              <= '0;
         bus.binary_value <= '0;
         bus.overflow     <= 1'b0;
         bus.error        <= 1'b0;
      end else begin
         state   <= state_nx;
         start_q <= bus.start;
         if (trig) begin
            bcd <= bcd_in;
            acc <= '0;
            cnt <= '0;
         end else if (state == SHIFT) begin
            bcd <= bcd_sh;
            acc <= acc_sh;
            cnt <= cnt + 1'b1;
         end
         if (state == SHIFT && last) begin
            bus.binary_value <= acc_w[BIN_WIDTH-1:0];
            bus.overflow     <= |(acc_w >> BIN_WIDTH);
            bus.error        <= 1'b0;
         end else if (trig && bad) begin
            bus.binary_value <= '0;
            bus.overflow     <= 1'b0;
            bus.error        <= 1'b1;
         end
      end
   end
   assign bus.ready = state == IDLE;
   assign bus.done  = state == DONE;
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed vectors with a result scoreboard for bcd_to_binary.
module tb_bcd_to_binary;
   localparam int SHIFTS = 27;
   typedef struct {
      logic [25:0] bin;
      logic        ovf;
      logic        err;
      int          lat;
   } exp_t;
   logic clk = 1'b0;
   logic rstN = 1'b0;
   int   n_checks = 0, n_fail = 0, cyc = 0, trig_cyc = 0, done_cnt = 0;
   logic chk_rdy = 1'b0;
   exp_t q[$];
   exp_t got;
   bcd_to_binary_if #(.N_DIGITS(8), .BIN_WIDTH(26)) bus();
   bcd_to_binary dut (.clk(clk), .rstN(rstN), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   // Monitor: every done pulse is matched against the oldest pending expectation.
   always @(negedge clk) begin
      if (chk_rdy) check("ready_after_done", bus.ready, 1);
      chk_rdy = bus.done;
      if (bus.done) begin
         done_cnt++;
         check("ready_during_done", bus.ready, 0);
         if (q.size() == 0) check("spurious_done", bus.done, 0);
         else begin
            got = q.pop_front();
            check("binary_value", bus.binary_value, got.bin);
            check("overflow", bus.overflow, got.ovf);
            check("error", bus.error, got.err);
            check("latency", cyc - trig_cyc, got.lat);
         end
      end
   end
   task automatic set_bcd(input logic [31:0] d);
      for (int i = 0; i < 8; i++) bus.BCD_value[i] = d[4*i +: 4];
   endtask
   task automatic push(input logic [25:0] b, input logic o, input logic e, input int lat);
      exp_t x;
      x.bin = b; x.ovf = o; x.err = e; x.lat = lat;
      q.push_back(x);
   endtask
   task automatic trigger(input logic [31:0] d);
      int t = 0;
      @(negedge clk);
      while (!bus.ready && t < 50) begin @(negedge clk); t++; end
      check("ready_before_start", bus.ready, 1);
      set_bcd(d);
      bus.start = 1'b1;
      @(posedge clk);
      #1 trig_cyc = cyc;
   endtask
   task automatic convert(input logic [31:0] d, input logic [25:0] b, input logic o,
                          input logic e, input int lat);
      int t = 0;
      push(b, o, e, lat);
      trigger(d);
      while (q.size() != 0 && t < 60) begin @(negedge clk); t++; end
      check("done_seen", q.size(), 0);
      q.delete();
      bus.start = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      int d0;
      bus.start = 1'b0;
      set_bcd(32'h0);
      repeat (3) @(negedge clk);
      check("rst_ready", bus.ready, 1);
      check("rst_done", bus.done, 0);
      check("rst_binary_value", bus.binary_value, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_error", bus.error, 0);
      rstN = 1'b1;
      repeat (2) @(negedge clk);
      convert(32'h00000162, 26'd162, 1'b0, 1'b0, SHIFTS);
      convert(32'h00043210, 26'd43210, 1'b0, 1'b0, SHIFTS);
      convert(32'h00000000, 26'd0, 1'b0, 1'b0, SHIFTS);
      convert(32'h67108863, 26'h3FFFFFF, 1'b0, 1'b0, SHIFTS);
      convert(32'h12345678, 26'd12345678, 1'b0, 1'b0, SHIFTS);
      convert(32'h67108864, 26'd0, 1'b1, 1'b0, SHIFTS);
      convert(32'h99999999, 26'd32891135, 1'b1, 1'b0, SHIFTS);
      // start held high for 100 cycles yields a single conversion
      d0 = done_cnt;
      push(26'd162, 1'b0, 1'b0, SHIFTS);
      trigger(32'h00000162);
      repeat (100) @(negedge clk);
      bus.start = 1'b0;
      check("held_start_dones", done_cnt - d0, 1);
      check("held_start_pending", q.size(), 0);
      q.delete();
      @(negedge clk);
      // a start pulse and operand change during SHIFT are ignored
      d0 = done_cnt;
      push(26'd43210, 1'b0, 1'b0, SHIFTS);
      trigger(32'h00043210);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      set_bcd(32'h99999999);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (50) @(negedge clk);
      check("shift_pulse_dones", done_cnt - d0, 1);
      check("shift_pulse_pending", q.size(), 0);
      q.delete();
      // reset mid-SHIFT abandons the conversion
      d0 = done_cnt;
      trigger(32'h00000162);
      repeat (10) @(posedge clk);
      #2 rstN = 1'b0;
      #1;
      check("midrst_done", bus.done, 0);
      check("midrst_ready", bus.ready, 1);
      check("midrst_binary_value", bus.binary_value, 0);
      check("midrst_overflow", bus.overflow, 0);
      @(negedge clk);
      rstN = 1'b1;
      repeat (40) @(negedge clk);
      check("midrst_no_done", done_cnt - d0, 0);
      bus.start = 1'b0;
      @(negedge clk);
      convert(32'h00000162, 26'd162, 1'b0, 1'b0, SHIFTS);
`ifdef BCD_DIGIT_CHECK_EN
      convert(32'h0000A123, 26'd0, 1'b0, 1'b1, 0);
      convert(32'h00000162, 26'd162, 1'b0, 1'b0, SHIFTS);
`endif
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential BCD-to-binary converter. It takes an 8-digit packed-BCD value and produces the equivalent unsigned binary value using reverse double-dabble: shift right, then subtract 3 from every digit that is 8 or more. It is the inverse of the existing binaryToBCD converter and uses the same start/ready/done handshake. It sits on the display/keypad path, where it turns decimal operands entered by the user back into binary for the processor cores.

## Interface
Parameters:
- N_DIGITS, 8, number of BCD input digits.
- BIN_WIDTH, 26, width of the binary result.
- Localparam SHIFTS = ceil(N_DIGITS·log2(10)), which is 27 at the defaults; this is the internal accumulator width and the iteration count.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rstN  in  1  asynchronous, active-low reset.
- start  in  1  level input; a conversion is requested on a 0→1 transition.
- BCD_value  in  [3:0] x [N_DIGITS-1:0]  unpacked digit array; index 0 is the least significant digit.
- binary_value  out  BIN_WIDTH  converted result; held until the next done.
- ready  out  1  high while idle and able to accept a start.
- done  out  1  one-cycle pulse when binary_value, overflow and error are valid.
- overflow  out  1  converted value ≥ 2^BIN_WIDTH; binary_value then holds the low BIN_WIDTH bits.
- error  out  1  an input digit was greater than 9 (only when BCD_DIGIT_CHECK_EN is defined, otherwise tied 0).

## Operation
- States:
  - IDLE: ready=1.
  - SHIFT: ready=0, runs the counter from 0 to SHIFTS-1.
  - DONE: ready=0, done=1.
- Start detection:
  - start_q registers start; it resets to 1, so a start held high through reset does not trigger a conversion.
  - A trigger is start=1 && start_q=0 && state==IDLE.
  - Edges on start outside IDLE are ignored and not queued.
- IDLE → SHIFT on a trigger:
  - Load the BCD register from BCD_value (N_DIGITS·4 bits).
  - Clear the accumulator (SHIFTS bits) and the counter.
- SHIFT, each cycle:
  - Shift {bcd, acc} right by 1; the bcd LSB enters acc MSB.
  - Then subtract 3 from each 4-bit digit of the shifted bcd that is ≥ 8.
  - Increment the counter.
  - After the shift with counter = SHIFTS-1, go to DONE.
- On entry to DONE, register the outputs:
  - binary_value = acc[BIN_WIDTH-1:0].
  - overflow = |acc[SHIFTS-1:BIN_WIDTH]; this is 0 when SHIFTS ≤ BIN_WIDTH.
  - error = 0.
- DONE → IDLE unconditionally after one cycle.
- binary_value, overflow and error hold their values until the next DONE entry.
- A new conversion needs start to be seen low, then high, in IDLE. Holding start high produces exactly one conversion.

## Timing
- Reset values: binary_value=0, overflow=0, error=0, done=0, ready=1, state=IDLE.
- Latency:
  - The trigger is sampled at edge E0.
  - Shifts happen at E1..E(SHIFTS).
  - done is high in the cycle after E(SHIFTS), which is 27 cycles after E0 at the defaults.
  - ready returns to 1 in the following cycle.
- Throughput: one conversion per SHIFTS+2 cycles at best, because of the start-low rearm.
- If rstN is asserted mid-SHIFT or in DONE:
  - All outputs immediately take their reset values.
  - The conversion is abandoned and no done is produced.
- BCD_value is sampled only at the trigger edge; changing it during SHIFT has no effect.

## Configuration
- BCD_DIGIT_CHECK_EN defined:
  - At the trigger, any input digit > 9 sends the block IDLE → DONE directly, skipping SHIFT.
  - Outputs in that case: error=1, binary_value=0, overflow=0.
  - done is high in the cycle after E0.
- BCD_DIGIT_CHECK_EN undefined:
  - No check is made; error is constant 0.
  - Digits > 9 are converted through the normal SHIFT path. The result is deterministic but not specified, and the bench must not check it.

## Test plan
- Digits 0,0,0,0,0,1,6,2; start 0→1 → done one cycle at E0+28 edges; binary_value=162, overflow=0, ready back to 1 next cycle.
- Digits 0,0,0,4,3,2,1,0 → binary_value=43210. Then all digits 0 → binary_value=0. Then 67108863 → binary_value=0x3FFFFFF, overflow=0.
- Digits 9,9,9,9,9,9,9,9 → overflow=1, binary_value=32891135 (99999999 − 2^26).
- start held high for 100 cycles → exactly one done pulse. A start pulse during SHIFT → ignored, no second done.
- rstN low at cycle 10 of SHIFT → binary_value=0, done=0, ready=1 immediately; no done after release until a new start edge.
- With BCD_DIGIT_CHECK_EN, digit[3]=4'hA → done at E0+1 edge, error=1, binary_value=0. The next valid conversion clears error to 0.
